dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
// - Multi-cycle data-memory responder: the memory-side end of the pipeline's load/store port.
// - Accepts one load/store request per valid/ready handshake and applies RV32I byte/half/word semantics.
// - Returns exactly one response per request after a programmable latency; the EX/MEM stage stalls on !req_ready.
// - Replaces the single-cycle data memory on the MEM-stage port; the DM_ADDRESS byte space is word-backed.
// PARAMETERS
// - DM_ADDRESS  9   byte-address width; storage = 2**(DM_ADDRESS-2) words
// - DATA_W      32  data width; only 32 is supported
// - LATENCY     2   cycles from accept to rsp_valid; legal range 1..15, elaboration error otherwise
// PORTS
// - clk         in   1           clock; all state updates on posedge
// - reset       in   1           synchronous reset, active-low (0 = in reset)
// - req_valid   in   1           request present
// - req_we      in   1           1 = store, 0 = load
// - req_addr    in   DM_ADDRESS  byte address
// - req_wdata   in   DATA_W      store data, right-aligned (SB uses [7:0], SH uses [15:0])
// - req_funct3  in   3           RV32I funct3 of the load/store
// - req_ready   out  1           responder can accept a request this cycle
// - rsp_valid   out  1           one-cycle response pulse; no backpressure
// - rsp_rdata   out  DATA_W      load result, already extended; 0 for stores and errors
// - rsp_err     out  1           misaligned access or illegal funct3; valid with rsp_valid
// BEHAVIOUR
// - Reset (reset==0 at posedge): state=IDLE, counter=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
// - Reset does not clear storage contents.
// - req_ready = (state==IDLE) && reset. It goes high in the first cycle after reset deasserts.
// - Accept: req_valid && req_ready at posedge k.
//   - we/addr/wdata/funct3 are captured into the request register at that edge.
//   - Request inputs are ignored whenever the responder is not in IDLE.
// - FSM states and transitions:
//   - IDLE -> WAIT on accept when LATENCY > 1; counter loads LATENCY-2.
//   - IDLE -> RESP on accept when LATENCY == 1.
//   - WAIT: decrement counter each cycle; -> RESP when counter == 0.
//   - RESP: rsp_valid=1 for exactly one cycle; -> IDLE unconditionally.
// - Timing: rsp_valid is high in cycle k+LATENCY (counted from the cycle after accept).
//   - Back-to-back throughput is one request per LATENCY+1 cycles.
// - Commit point: store write and load read both happen at the RESP edge.
//   - A load that follows a store therefore observes the stored data.
// - Addressing: word index = addr[DM_ADDRESS-1:2]; byte lane = addr[1:0]; little-endian.
// - Loads:
//   - 000 LB: sign-extend byte.
//   - 001 LH: sign-extend half.
//   - 010 LW: full word.
//   - 100 LBU: zero-extend byte.
//   - 101 LHU: zero-extend half.
// - Stores:
//   - 000 SB writes 1 lane; 001 SH writes 2 lanes; 010 SW writes 4 lanes.
//   - Unwritten lanes are preserved (byte-enable write).
// - Errors: set rsp_err=1, rsp_rdata=0, and suppress any write. Error cases are:
//   - Half access with addr[0]==1.
//   - Word access with addr[1:0]!=0.
//   - Load funct3 in {011,110,111}.
//   - Store funct3 not in {000,001,010}.
//   Error responses keep normal latency.
// - Between responses: rsp_rdata and rsp_err return to 0 in every cycle with rsp_valid==0.
// - Reset mid-operation: a pending request is dropped, no write occurs, no response is issued.
// - Address wrap: none; top byte address 2**DM_ADDRESS-1 is reachable only by byte access.
// STRUCTURE
// - dmem_pkg holds:
//   - enum funct3_e {F3_B, F3_H, F3_W, F3_BU=4, F3_HU=5}
//   - enum state_e {IDLE, WAIT, RESP}
//   - struct dmem_req_t {we, addr, wdata, funct3}
//   - function is_misaligned(funct3, addr[1:0])
// - Sub-module dmem_lane_align (combinational):
//   - Inputs funct3 and lane; word in / wdata in.
//   - Outputs extended rdata, merged write word, and 4-bit byte enable.
// - Top level holds the FSM, latency counter, request register and word array.
// TESTING
// - Reset then idle: reset=0 for 3 cycles -> req_ready=0, rsp_valid=0; after release req_ready=1 next cycle.
// - Word round-trip (LATENCY=2):
//   - SW addr=0x010 data=0xDEADBEEF -> rsp_valid 2 cycles after accept, rsp_err=0.
//   - LW addr=0x010 -> rsp_rdata=0xDEADBEEF.
// - Byte/half extension, after SW 0x010=0x80FF7F01:
//   - LB 0x013 -> 0xFFFFFF80; LBU 0x013 -> 0x00000080.
//   - LH 0x012 -> 0xFFFF80FF; LHU 0x010 -> 0x00007F01.
// - Partial store: SW 0x020=0x11223344, SB 0x021=0xAA, SH 0x022=0xBEEF -> LW 0x020 = 0xBEEFAA44.
// - Errors:
//   - LW 0x011 -> rsp_err=1, rdata=0.
//   - SH 0x021 -> rsp_err=1, and a following LW 0x020 is unchanged.
//   - Load funct3=011 -> rsp_err=1.
// - Handshake/reset:
//   - req_valid held high with 3 queued requests -> exactly 3 rsp_valid pulses, spaced LATENCY+1 cycles.
//   - Inputs changed while busy have no effect.
//   - reset=0 during WAIT of an SW -> no rsp_valid, and memory keeps its old value.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: funct3 codes,
// FSM states, the captured request and the alignment check.
package dmem_pkg;

    localparam int DM_ADDR_W = 9;
    localparam int DATA_W    = 32;

    typedef enum logic [2:0] {
        F3_B  = 3'd0,
        F3_H  = 3'd1,
        F3_W  = 3'd2,
        F3_BU = 3'd4,
        F3_HU = 3'd5
    } funct3_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    typedef struct packed {
        logic                 we;
        logic [DM_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]    wdata;
        logic [2:0]           funct3;
    } dmem_req_t;

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] lane);
        logic mis;
        mis = 1'b0;
        case (funct3)
            F3_H, F3_HU: mis = lane[0];
            F3_W:        mis = (lane != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: extracts and extends load data from a memory word and
// merges right-aligned store data into it under a byte enable.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] word_in,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [31:0] wr_word,
    output logic [3:0]  be
);

    logic [31:0] rd_shift;
    logic [31:0] wr_shift;

    always_comb begin
        rd_shift = word_in >> {lane, 3'b000};
        wr_shift = wdata << {lane, 3'b000};
        rdata    = '0;
        be       = '0;
        case (funct3)
            F3_B:  rdata = {{24{rd_shift[7]}}, rd_shift[7:0]};
            F3_BU: rdata = {24'h0, rd_shift[7:0]};
            F3_H:  rdata = {{16{rd_shift[15]}}, rd_shift[15:0]};
            F3_HU: rdata = {16'h0, rd_shift[15:0]};
            F3_W:  rdata = word_in;
            default: rdata = '0;
        endcase
        case (funct3)
            F3_B:    be = 4'b0001 << lane;
            F3_H:    be = 4'b0011 << lane;
            F3_W:    be = 4'b1111;
            default: be = '0;
        endcase
        for (int unsigned i = 0; i < 4; i++) begin
            wr_word[8*i +: 8] = be[i] ? wr_shift[8*i +: 8] : word_in[8*i +: 8];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one request per handshake, one response
// LATENCY cycles later, RV32I byte/half/word load/store semantics.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [2:0]            req_funct3,
    output logic                  req_ready,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err
);

    localparam int WORDS = 2 ** (DM_ADDRESS - 2);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("dmem_responder: LATENCY must be in 1..15");
    end
    if (DATA_W != 32) begin : g_bad_width
        $error("dmem_responder: only DATA_W == 32 is supported");
    end
    if (DM_ADDRESS != DM_ADDR_W) begin : g_bad_addr
        $error("dmem_responder: DM_ADDRESS must match dmem_pkg::DM_ADDR_W");
    end

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    dmem_req_t   req_q, req_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic [31:0] mem_q [WORDS];

    logic                  enter_resp;
    logic                  access_err;
    logic                  illegal_f3;
    logic                  mem_we;
    logic [DM_ADDRESS-3:0] widx;
    logic [31:0]           ld_data;
    logic [31:0]           wr_word;
    logic [3:0]            be;

    assign req_ready = (state_q == IDLE) && reset;

    // Commit logic works on req_d, not req_q: with LATENCY == 1 the commit edge
    // is the accept edge itself, so the request register is not loaded yet.
    assign widx = req_d.addr[DM_ADDRESS-1:2];

    dmem_lane_align u_align (
        .funct3  (req_d.funct3),
        .lane    (req_d.addr[1:0]),
        .word_in (mem_q[widx]),
        .wdata   (req_d.wdata),
        .rdata   (ld_data),
        .wr_word (wr_word),
        .be      (be)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        enter_resp  = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    req_d = '{we: req_we, addr: req_addr, wdata: req_wdata, funct3: req_funct3};
                    if (LATENCY > 1) begin
                        state_d = WAIT;
                        cnt_d   = 4'(LATENCY - 2);
                    end else begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (req_d.we) illegal_f3 = !(req_d.funct3 inside {3'd0, 3'd1, 3'd2});
        else          illegal_f3 = req_d.funct3 inside {3'd3, 3'd6, 3'd7};
        access_err = illegal_f3 || is_misaligned(req_d.funct3, req_d.addr[1:0]);
        mem_we     = enter_resp && req_d.we && !access_err && reset;

        if (enter_resp) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = access_err;
            rsp_rdata_d = (access_err || req_d.we) ? '0 : ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Storage is deliberately outside reset; byte enables are folded into wr_word.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[widx] <= wr_word;
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: the driver queues expected responses,
// an independent negedge monitor pops and compares them.
module tb_dmem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [8:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [2:0]  req_funct3 = '0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .LATENCY(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   rsp_cyc_q[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (rsp_valid) begin
                rsp_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 32'(rsp_valid), 32'h0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                    chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
                end
            end else begin
                chk("idle_outputs_zero", {rsp_rdata[30:0], rsp_err}, 32'h0);
            end
        end
    end

    task automatic do_req(input logic we, input logic [8:0] addr, input logic [31:0] wdata,
                          input logic [2:0] f3, input logic [31:0] exp_rd, input logic exp_err,
                          input logic hold);
        int n;
        exp_t e;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        req_funct3 = f3;
        n = 0;
        while (!req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 32'(req_ready), 32'h1);
        end else begin
            e.rdata = exp_rd;
            e.err   = exp_err;
            e.cyc   = cyc + LAT;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 32'(exp_q.size()), 32'h0);
        exp_q.delete();
    endtask

    initial begin
        int base;

        // reset held for three cycles
        repeat (3) begin
            @(negedge clk);
            chk("reset_req_ready", 32'(req_ready), 32'h0);
            chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 32'(req_ready), 32'h1);

        // word round trip
        do_req(1, 9'h010, 32'hDEADBEEF, 3'b010, 32'h0, 0, 0);
        do_req(0, 9'h010, 32'h0, 3'b010, 32'hDEADBEEF, 0, 0);

        // byte/half extension
        do_req(1, 9'h010, 32'h80FF7F01, 3'b010, 32'h0, 0, 0);
        do_req(0, 9'h013, 32'h0, 3'b000, 32'hFFFFFF80, 0, 0);
        do_req(0, 9'h013, 32'h0, 3'b100, 32'h00000080, 0, 0);
        do_req(0, 9'h012, 32'h0, 3'b001, 32'hFFFF80FF, 0, 0);
        do_req(0, 9'h010, 32'h0, 3'b101, 32'h00007F01, 0, 0);
        do_req(0, 9'h011, 32'h0, 3'b000, 32'h0000007F, 0, 0);
        do_req(0, 9'h012, 32'h0, 3'b101, 32'h000080FF, 0, 0);

        // partial stores keep unwritten lanes
        do_req(1, 9'h020, 32'h11223344, 3'b010, 32'h0, 0, 0);
        do_req(1, 9'h021, 32'hFFFFFFAA, 3'b000, 32'h0, 0, 0);
        do_req(1, 9'h022, 32'h1234BEEF, 3'b001, 32'h0, 0, 0);
        do_req(0, 9'h020, 32'h0, 3'b010, 32'hBEEFAA44, 0, 0);

        // errors
        do_req(0, 9'h011, 32'h0, 3'b010, 32'h0, 1, 0);
        do_req(1, 9'h021, 32'h0000FFFF, 3'b001, 32'h0, 1, 0);
        do_req(0, 9'h020, 32'h0, 3'b010, 32'hBEEFAA44, 0, 0);
        do_req(0, 9'h020, 32'h0, 3'b011, 32'h0, 1, 0);
        do_req(1, 9'h020, 32'h0, 3'b100, 32'h0, 1, 0);
        do_req(0, 9'h013, 32'h0, 3'b101, 32'h0, 1, 0);
        do_req(0, 9'h020, 32'h0, 3'b010, 32'hBEEFAA44, 0, 0);

        // top of the byte space
        do_req(1, 9'h1FC, 32'h01020304, 3'b010, 32'h0, 0, 0);
        do_req(1, 9'h1FF, 32'h0000005A, 3'b000, 32'h0, 0, 0);
        do_req(0, 9'h1FF, 32'h0, 3'b100, 32'h0000005A, 0, 0);
        do_req(0, 9'h1FC, 32'h0, 3'b010, 32'h5A020304, 0, 0);
        drain();

        // req_valid held across three queued requests
        base = rsp_cyc_q.size();
        do_req(0, 9'h010, 32'h0, 3'b010, 32'h80FF7F01, 0, 1);
        do_req(0, 9'h020, 32'h0, 3'b100, 32'h00000044, 0, 1);
        do_req(0, 9'h020, 32'h0, 3'b001, 32'hFFFFAA44, 0, 0);
        drain();
        chk("burst_count", 32'(rsp_cyc_q.size() - base), 32'd3);
        if (rsp_cyc_q.size() - base == 3) begin
            chk("burst_gap0", 32'(rsp_cyc_q[base+1] - rsp_cyc_q[base]), 32'(LAT + 1));
            chk("burst_gap1", 32'(rsp_cyc_q[base+2] - rsp_cyc_q[base+1]), 32'(LAT + 1));
        end

        // inputs toggled while busy are ignored
        do_req(0, 9'h020, 32'h0, 3'b010, 32'hBEEFAA44, 0, 0);
        for (int i = 0; i < LAT; i++) begin
            @(negedge clk);
            req_valid  = (i < LAT - 1);
            req_we     = 1'b1;
            req_addr   = 9'h020;
            req_wdata  = 32'h0;
            req_funct3 = 3'b010;
        end
        req_valid = 1'b0;
        drain();
        do_req(0, 9'h020, 32'h0, 3'b010, 32'hBEEFAA44, 0, 0);

        // reset during WAIT drops a pending store
        do_req(1, 9'h030, 32'hCAFEF00D, 3'b010, 32'h0, 0, 0);
        drain();
        base = rsp_cyc_q.size();
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_addr   = 9'h030;
        req_wdata  = 32'h12345678;
        req_funct3 = 3'b010;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_mid_rsp_valid", 32'(rsp_valid), 32'h0);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        chk("reset_mid_no_rsp", 32'(rsp_cyc_q.size() - base), 32'h0);
        do_req(0, 9'h030, 32'h0, 3'b010, 32'hCAFEF00D, 0, 0);
        drain();

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
